// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core data-memory port.
//
// Register window (BASE_ADDR, 16 bytes, offset = read_address[3:2]):
//   0x0 TXDATA  W: push write_data[7:0] into the TX FIFO; R: 0
//   0x4 STATUS  R: {level[15:8], overflow[3], empty[2], full[1], in_flight[0]}
//               W: write_data[3]=1 clears the sticky overflow flag
//   0x8 CTRL    R/W: bit0 enable (reset 1), bit1 parity_odd (parity build only)
//   0xC         R: 0, writes ignored
//
// Ports:
//   clk, reset (async, active low)
//   Memwrite, Memread, read_address, write_data : core data-memory request
//   MemData_out : combinational load data, 0 unless (hit && Memread)
//   hit         : read_address falls inside the register window
//   tx          : registered serial output, idles high
//   busy        : frame in flight or FIFO non-empty
//
// Optional feature: define MMIO_UART_TX_PARITY_EN to insert a parity bit
// between the data bits and the stop bit (even parity, inverted by parity_odd).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Memwrite,
  input  logic        Memread,
  input  logic [31:0] read_address,
  input  logic [31:0] write_data,
  output logic [31:0] MemData_out,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              enable_q, enable_d;
  logic              parity_odd_q, parity_odd_d;

  logic [1:0]        offset;
  logic              wr_en, push_req, push, pop;
  logic              fifo_full, fifo_empty, bit_end;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign unused_bits = ^{read_address[1:0], write_data[31:8]};

  assign hit        = (read_address[31:4] == BASE_ADDR[31:4]);
  assign offset     = read_address[3:2];
  assign wr_en      = hit && Memwrite;
  assign push_req   = wr_en && (offset == 2'd0);
  assign fifo_full  = (level_q == LvlFull);
  assign fifo_empty = (level_q == '0);
  // A store while full is dropped even if a pop frees a slot on the same edge.
  assign push       = push_req && !fifo_full;
  assign bit_end    = (cnt_q == CntMax);

  assign tx   = tx_q;
  assign busy = (state_q != StIdle) || !fifo_empty;

  // Serializer next state; tx_d is the level driven after the coming edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            tx_d    = (^data_q) ^ parity_odd_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (enable_q && !fifo_empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // FIFO level and register-file next state.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LvlW'(1);
    end

    overflow_d = overflow_q;
    if (push_req && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wr_en && (offset == 2'd1) && write_data[3]) begin
      overflow_d = 1'b0;
    end

    enable_d     = enable_q;
    parity_odd_d = parity_odd_q;
    if (wr_en && (offset == 2'd2)) begin
      enable_d = write_data[0];
`ifdef MMIO_UART_TX_PARITY_EN
      parity_odd_d = write_data[1];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      data_q       <= '0;
      tx_q         <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      enable_q     <= 1'b1;
      parity_odd_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
      tx_q         <= tx_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      enable_q     <= enable_d;
      parity_odd_q <= parity_odd_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; the level counter qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= write_data[7:0];
  end

  always_comb begin
    rd_data = '0;
    unique case (offset)
      2'd1: begin
        rd_data[0]    = (state_q != StIdle);
        rd_data[1]    = fifo_full;
        rd_data[2]    = fifo_empty;
        rd_data[3]    = overflow_q;
        rd_data[15:8] = 8'(level_q);
      end
      2'd2: begin
        rd_data[0] = enable_q;
`ifdef MMIO_UART_TX_PARITY_EN
        rd_data[1] = parity_odd_q;
`endif
      end
      default: rd_data = '0;
    endcase
    MemData_out = (hit && Memread) ? rd_data : 32'h0;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table vectors for the register map,
// hand sequences for frame timing and corner cases, then random traffic
// checked cycle by cycle against a frame-level reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] Base = 32'h0000_1000;
  localparam int C = 16;
  localparam int D = 8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam bit Par = 1'b1;
  localparam logic [31:0] CtrlAll = 32'h3;
`else
  localparam bit Par = 1'b0;
  localparam logic [31:0] CtrlAll = 32'h1;
`endif
  localparam int Nb = Par ? 11 : 10;
  localparam int Fl = Nb * C;

  logic        clk, reset, Memwrite, Memread, hit, tx, busy;
  logic [31:0] read_address, write_data, MemData_out;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Memwrite    (Memwrite),
    .Memread     (Memread),
    .read_address(read_address),
    .write_data  (write_data),
    .MemData_out (MemData_out),
    .hit         (hit),
    .tx          (tx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "position within the current frame".
  logic [7:0]  m_q[$];
  bit          m_en, m_podd, m_ovf, m_in;
  int          m_pos;
  logic [10:0] m_bits;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_en = 1'b1; m_podd = 1'b0; m_ovf = 1'b0; m_in = 1'b0; m_pos = 0; m_bits = '1;
    end else begin : step
      int   lvl;
      bit   pop, inwin;
      lvl   = m_q.size();
      pop   = 1'b0;
      inwin = (read_address[31:4] == Base[31:4]);
      if (!m_in) begin
        if (m_en && lvl != 0) pop = 1'b1;
      end else begin
        m_pos++;
        if (m_pos == Fl) begin
          if (m_en && lvl != 0) pop = 1'b1;
          else m_in = 1'b0;
        end else if (Par && m_pos == 9 * C) begin
          m_bits[9] = (^m_bits[8:1]) ^ m_podd;
        end
      end
      if (pop) begin
        m_bits = {2'b11, m_q.pop_front(), 1'b0};
        m_in   = 1'b1;
        m_pos  = 0;
      end
      if (Memwrite && inwin) begin
        case (read_address[3:2])
          2'd0: if (lvl == D) m_ovf = 1'b1; else m_q.push_back(write_data[7:0]);
          2'd1: if (write_data[3]) m_ovf = 1'b0;
          2'd2: begin m_en = write_data[0]; if (Par) m_podd = write_data[1]; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:4] != Base[31:4]) return '0;
    case (a[3:2])
      2'd1: r = {16'h0, 8'(m_q.size()), 4'h0, m_ovf, m_q.size() == 0, m_q.size() == D, m_in};
      2'd2: r = {30'h0, Par ? m_podd : 1'b0, m_en};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Continuous tx/busy comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      check("tx_model", {31'h0, tx}, {31'h0, m_in ? m_bits[m_pos / C] : 1'b1});
      check("busy_model", {31'h0, busy}, {31'h0, m_in || m_q.size() != 0});
    end
  end

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    Memwrite = we; Memread = re; read_address = a; write_data = wd;
  endtask

  task automatic clear_bus();
    Memwrite = 1'b0; Memread = 1'b0; read_address = '0; write_data = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b0, a, wd);
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    drive(1'b0, 1'b1, a, 32'h0);
    #1 d = MemData_out;
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("wait_idle_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic send_parity_frame(input string name, input logic exp_par);
    logic rec [0:200];
    logic brec [0:200];
    int   len;
    store(Base, 32'h07);
    rec[0] = tx; brec[0] = busy;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      rec[k] = tx; brec[k] = busy;
    end
    len = -1;
    for (int k = 200; k >= 1; k--) if (!brec[k]) len = k - 1;
    check({name, "_len"}, len, 176);
    check({name, "_bit"}, {31'h0, rec[153]}, {31'h0, exp_par});
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] d;
    logic        rec [0:340];
    logic [7:0]  b1, b2;

    reset = 1'b0;
    clear_bus();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Register map vectors.
    vecs.push_back('{1'b0, 1'b1, 32'h1004, 32'h0,        32'h4,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h2004, 32'h0,        32'h0,   1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h1008, 32'h0,        32'h1,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h1000, 32'h0,        32'h0,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h100C, 32'h0,        32'h0,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h1006, 32'h0,        32'h4,   1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h1008, 32'h0,        32'h0,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h1008, 32'h0,        32'h0,   1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h1008, 32'hFFFF_FFFF, 32'h0,  1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h1008, 32'h0,        CtrlAll, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h100C, 32'hFFFF_FFFF, 32'h0,  1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h2000, 32'h55,       32'h0,   1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h1004, 32'h0,        32'h4,   1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h1004, 32'h0,        32'h0,   1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h1008, 32'h1,        32'h0,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h1008, 32'h0,        32'h1,   1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h1013, 32'h0,        32'h0,   1'b0});
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_rd", i), MemData_out, vecs[i].exp_rd);
      check($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
      @(posedge clk); #1;
    end
    clear_bus();
    wait_idle();

    // Single 0x55 frame: exact bit timing and busy release.
    store(Base, 32'h55);
    for (int k = 1; k <= 161; k++) begin
      logic [7:0] v;
      logic       e;
      v = 8'h55;
      @(posedge clk); #1;
      if (k <= 16) e = 1'b0;
      else if (k <= 144) e = v[(k - 17) / 16];
      else e = 1'b1;
      check($sformatf("f55_tx_k%0d", k), {31'h0, tx}, {31'h0, e});
      if (k >= 160) check($sformatf("f55_busy_k%0d", k), {31'h0, busy}, {31'h0, k == 160});
    end

    // Back-to-back frames with no idle gap.
    store(Base, 32'hA5);
    store(Base, 32'h3C);
    rec[1] = tx;
    for (int k = 2; k <= 330; k++) begin
      @(posedge clk); #1;
      rec[k] = tx;
    end
    for (int i = 0; i < 8; i++) begin
      b1[i] = rec[25 + 16 * i];
      b2[i] = rec[185 + 16 * i];
    end
    check("b2b_start1", {31'h0, rec[1]}, 32'h0);
    check("b2b_byte1", {24'h0, b1}, 32'hA5);
    check("b2b_stop1", {31'h0, rec[160]}, 32'h1);
    check("b2b_nogap", {31'h0, rec[161]}, 32'h0);
    check("b2b_byte2", {24'h0, b2}, 32'h3C);
    wait_idle();

    // Disabled FIFO fill, overflow and its clear.
    store(Base + 32'h8, 32'h0);
    for (int i = 0; i < 9; i++) store(Base, i);
    load(Base + 32'h4, d);
    check("ovf_status", d, 32'h0000_080A);
    check("ovf_tx_idle", {31'h0, tx}, 32'h1);
    store(Base + 32'h4, 32'h8);
    load(Base + 32'h4, d);
    check("ovf_cleared", d, 32'h0000_0802);
    do_reset();

    // Reset mid-DATA aborts the frame asynchronously.
    store(Base, 32'h0F);
    repeat (60) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_async_tx", {31'h0, tx}, 32'h1);
    check("rst_async_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    load(Base + 32'h4, d);
    check("rst_status", d, 32'h4);
    repeat (200) @(posedge clk);
    #1;
    check("rst_no_resume", {31'h0, tx}, 32'h1);

`ifdef MMIO_UART_TX_PARITY_EN
    send_parity_frame("par_even", 1'b1);
    store(Base + 32'h8, 32'h3);
    send_parity_frame("par_odd", 1'b0);
    store(Base + 32'h8, 32'h1);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [31:0] a, wd;
      r  = $urandom_range(0, 99);
      wd = $urandom;
      a  = (($urandom_range(0, 7) == 0) ? 32'h2000 : Base) + 32'($urandom_range(0, 15));
      if (r < 5) drive(1'b1, 1'b0, Base, wd);
      else if (r < 7) drive(1'b1, 1'b0, Base + 32'h8, {wd[31:1], $urandom_range(0, 4) != 0});
      else if (r < 9) drive(1'b1, 1'b0, Base + 32'h4, wd);
      else if (r < 10) drive(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? 32'h100C : 32'h3000, wd);
      else if (r < 45) drive(1'b0, 1'b1, a, 32'h0);
      else drive(1'b0, 1'b0, a, wd);
      #1;
      check("rnd_rd", MemData_out, Memread ? model_read(read_address) : 32'h0);
      check("rnd_hit", {31'h0, hit}, {31'h0, read_address[31:4] == Base[31:4]});
    end
    @(posedge clk); #1;
    clear_bus();
    store(Base + 32'h8, 32'h1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
